spi_mnrch_multi: RTL and testbench

- Parametrised SPI monarch, successor to the fixed 16-bit, mode-0, single-target monarch.
- Generalised in word width, SCLK rate and number of chip selects.
- Adds runtime SPI mode (CPOL/CPHA) per transaction, and multi-word bursts that hold SS_n low between words.
- Sits between the control logic and SPI peripherals such as the inertial sensor.

---
 rtl/spi_mnrch_multi.sv | 166 ++++++++++++++++
 tb/tb_spi_mnrch_multi.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mnrch_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_mnrch_multi : parametrised SPI monarch with runtime CPOL/CPHA, multiple
//                   chip selects and held-SS_n multi-word bursts.  Rev 1.0
// ---------------------------------------------------------------------------

module spi_mnrch_multi #(
  parameter int DATA_W   = 16,
  parameter int SCLK_DIV = 32,
  parameter int NUM_SS   = 1,
  parameter int SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snd,
  input  logic [DATA_W-1:0] cmd,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [1:0]        mode,
  input  logic              hold,
  input  logic              rls,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_SS-1:0] SS_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] resp
);

  localparam int H  = SCLK_DIV / 2;
  localparam int CW = $clog2(H + 1);
  localparam int TW = $clog2(2 * DATA_W);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FRONT = 3'd1;
  localparam logic [2:0] XFER  = 3'd2;
  localparam logic [2:0] BACK  = 3'd3;
  localparam logic [2:0] HELD  = 3'd4;

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [TW-1:0]     tcnt;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] resp_r;
  logic [NUM_SS-1:0] ss_n_r;
  logic              sample;
  logic              cpol;
  logic              cpha;
  logic              hold_l;
  logic              sclk_r;
  logic              done_r;
  logic              cnt_end;
  logic              lead;

  assign cnt_end = (cnt == CW'(H - 1));
  // Even toggle index means SCLK is about to move away from CPOL.
  assign lead    = ~tcnt[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      tcnt   <= '0;
      sreg   <= '0;
      resp_r <= '0;
      ss_n_r <= '1;
      sample <= 1'b0;
      cpol   <= 1'b0;
      cpha   <= 1'b0;
      hold_l <= 1'b0;
      sclk_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snd) begin
            sreg   <= cmd;
            cpol   <= mode[1];
            cpha   <= mode[0];
            hold_l <= hold;
            sclk_r <= mode[1];
            done_r <= 1'b0;
            cnt    <= '0;
            for (int i = 0; i < NUM_SS; i++) begin
              ss_n_r[i] <= (ss_sel != SS_W'(i));
            end
            state  <= FRONT;
          end
        end

        FRONT: begin
          if (cnt_end) begin
            cnt   <= '0;
            tcnt  <= '0;
            state <= XFER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        XFER: begin
          if (cnt_end) begin
            cnt    <= '0;
            sclk_r <= ~sclk_r;
            tcnt   <= tcnt + 1'b1;
            if (lead != cpha) begin
              sample <= MISO;
            end
            // CPHA=1 skips the first leading edge; its last shift lands in BACK.
            if ((cpha && lead && (tcnt != '0)) || (!cpha && !lead)) begin
              sreg <= {sreg[DATA_W-2:0], sample};
            end
            if (tcnt == TW'(2 * DATA_W - 1)) begin
              state <= BACK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        BACK: begin
          sclk_r <= cpol;
          cnt    <= cnt + 1'b1;
          if ((cnt == '0) && cpha) begin
            sreg <= {sreg[DATA_W-2:0], sample};
          end
          if (cnt_end && !hold_l) begin
            ss_n_r <= '1;
          end
          if (cnt == CW'(H)) begin
            cnt    <= '0;
            resp_r <= sreg;
            done_r <= 1'b1;
            state  <= hold_l ? HELD : IDLE;
          end
        end

        HELD: begin
          if (rls) begin
            ss_n_r <= '1;
            state  <= IDLE;
          end else if (snd) begin
            sreg   <= cmd;
            hold_l <= hold;
            done_r <= 1'b0;
            cnt    <= '0;
            tcnt   <= '0;
            state  <= XFER;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign SCLK = sclk_r;
  assign MOSI = sreg[DATA_W-1];
  assign SS_n = ss_n_r;
  assign busy = (state == FRONT) || (state == XFER) || (state == BACK);
  assign done = done_r;
  assign resp = resp_r;

endmodule

`default_nettype wire

// File: tb/tb_spi_mnrch_multi.sv
`default_nettype none
// Bench for spi_mnrch_multi: default instance with a WHO_AM_I sensor model,
// plus 8-bit/3-SS and 24-bit loopback instances.

module tb_spi_mnrch_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // ---------------- instance 0: defaults, sensor model -----------------
  logic        rst0 = 1'b1, snd0 = 1'b0, hold0 = 1'b0, rls0 = 1'b0;
  logic [15:0] cmd0 = '0;
  logic [0:0]  ss0 = '0;
  logic [1:0]  mode0 = '0;
  logic        miso0 = 1'b0;
  logic        sclk0, mosi0, busy0, done0;
  logic [0:0]  ssn0;
  logic [15:0] resp0;

  spi_mnrch_multi u0 (
    .clk(clk), .rst(rst0), .snd(snd0), .cmd(cmd0), .ss_sel(ss0), .mode(mode0),
    .hold(hold0), .rls(rls0), .MISO(miso0), .SCLK(sclk0), .MOSI(mosi0),
    .SS_n(ssn0), .busy(busy0), .done(done0), .resp(resp0)
  );

  // ---------------- instance 1: 8-bit, 3 chip selects, loopback --------
  logic        rst1 = 1'b1, snd1 = 1'b0, hold1 = 1'b0, rls1 = 1'b0;
  logic [7:0]  cmd1 = '0;
  logic [1:0]  ss1 = '0;
  logic [1:0]  mode1 = '0;
  logic        sclk1, mosi1, busy1, done1;
  logic [2:0]  ssn1;
  logic [7:0]  resp1;

  spi_mnrch_multi #(.DATA_W(8), .SCLK_DIV(4), .NUM_SS(3)) u1 (
    .clk(clk), .rst(rst1), .snd(snd1), .cmd(cmd1), .ss_sel(ss1), .mode(mode1),
    .hold(hold1), .rls(rls1), .MISO(mosi1), .SCLK(sclk1), .MOSI(mosi1),
    .SS_n(ssn1), .busy(busy1), .done(done1), .resp(resp1)
  );

  // ---------------- instance 2: 24-bit loopback -------------------------
  logic        rst2 = 1'b1, snd2 = 1'b0, hold2 = 1'b0, rls2 = 1'b0;
  logic [23:0] cmd2 = '0;
  logic [0:0]  ss2 = '0;
  logic [1:0]  mode2 = '0;
  logic        sclk2, mosi2, busy2, done2;
  logic [0:0]  ssn2;
  logic [23:0] resp2;

  spi_mnrch_multi #(.DATA_W(24), .SCLK_DIV(8), .NUM_SS(1)) u2 (
    .clk(clk), .rst(rst2), .snd(snd2), .cmd(cmd2), .ss_sel(ss2), .mode(mode2),
    .hold(hold2), .rls(rls2), .MISO(mosi2), .SCLK(sclk2), .MOSI(mosi2),
    .SS_n(ssn2), .busy(busy2), .done(done2), .resp(resp2)
  );

  // ---------------- scoreboards ----------------------------------------
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  int acc0 = 0, acc1 = 0, acc2 = 0;

  // ---------------- monitors and sensor model (negedge sampling) --------
  logic       sclk0_p = 1'b0, mosi0_p = 1'b0, sclk1_p = 1'b0, ssn1_p0 = 1'b0;
  int         ss_low0 = 0, rises0 = 0, badper0 = 0, mosibad0 = 0, last0 = 0;
  int         nlow1 = 0, bad1 = 0, ss_rise1 = 0, rises1 = 0;
  logic [2:0] exp_ssn1 = 3'b111;
  logic [7:0] shin = '0, dout = '0, sel;
  int         rc = 0;

  assign sel = (shin == 8'h8F) ? 8'h6A : 8'h00;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    sclk0_p <= sclk0;
    mosi0_p <= mosi0;
    sclk1_p <= sclk1;
    ssn1_p0 <= ssn1[0];

    if (ssn0[0] === 1'b0) ss_low0 <= ss_low0 + 1;
    if (ssn0[0] === 1'b1) last0 <= 0;
    if (sclk0 === 1'b1 && sclk0_p === 1'b0) begin
      rises0 <= rises0 + 1;
      if (mosi0 !== mosi0_p) mosibad0 <= mosibad0 + 1;
      if (last0 != 0 && (cyc - last0) != 32) badper0 <= badper0 + 1;
      last0 <= cyc;
    end

    // Mode-0 target: capture address on rising SCLK, drive data on falling.
    if (ssn0[0] !== 1'b0) begin
      rc    <= 0;
      miso0 <= 1'b0;
    end else if (sclk0 === 1'b1 && sclk0_p === 1'b0) begin
      shin <= {shin[6:0], mosi0};
      rc   <= rc + 1;
    end else if (sclk0 === 1'b0 && sclk0_p === 1'b1 && rc >= 8) begin
      if (rc == 8) begin
        miso0 <= sel[7];
        dout  <= {sel[6:0], 1'b0};
      end else begin
        miso0 <= dout[7];
        dout  <= {dout[6:0], 1'b0};
      end
    end

    if (ssn1 !== 3'b111 && ssn1 !== 3'bxxx) nlow1 <= nlow1 + 1;
    if (ssn1 !== 3'b111 && ssn1 !== exp_ssn1 && ssn1 !== 3'bxxx) bad1 <= bad1 + 1;
    if (ssn1[0] === 1'b1 && ssn1_p0 === 1'b0) ss_rise1 <= ss_rise1 + 1;
    if (sclk1 === 1'b1 && sclk1_p === 1'b0) rises1 <= rises1 + 1;
  end

  // ---------------- helpers ---------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start0(input logic [15:0] c, input logic [31:0] e);
    snd0 = 1'b1; cmd0 = c;
    q0.push_back(e);
    step();
    snd0 = 1'b0; acc0 = cyc;
  endtask

  task automatic finish0(output int lat);
    while (done0 !== 1'b1 && (cyc - acc0) < 5000) step();
    lat = cyc - acc0;
    chk("resp0", {16'h0, resp0}, q0.pop_front());
  endtask

  task automatic start1(input logic [7:0] c, input logic [1:0] s, input logic [1:0] m,
                        input logic h, input logic [31:0] e);
    snd1 = 1'b1; cmd1 = c; ss1 = s; mode1 = m; hold1 = h;
    q1.push_back(e);
    step();
    snd1 = 1'b0; acc1 = cyc;
  endtask

  task automatic finish1(output int lat);
    while (done1 !== 1'b1 && (cyc - acc1) < 5000) step();
    lat = cyc - acc1;
    chk("resp1", {24'h0, resp1}, q1.pop_front());
  endtask

  task automatic start2(input logic [23:0] c, input logic [1:0] m, input logic [31:0] e);
    snd2 = 1'b1; cmd2 = c; mode2 = m;
    q2.push_back(e);
    step();
    snd2 = 1'b0; acc2 = cyc;
  endtask

  task automatic finish2(output int lat);
    while (done2 !== 1'b1 && (cyc - acc2) < 5000) step();
    lat = cyc - acc2;
    chk("resp2", {8'h0, resp2}, q2.pop_front());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence -----------------------------------
  initial begin
    int lat, s0, s1, s2, s3;

    repeat (3) step();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    step();

    chk("rst_ssn0",  {31'h0, ssn0},  32'h1);
    chk("rst_sclk0", {31'h0, sclk0}, 32'h0);
    chk("rst_mosi0", {31'h0, mosi0}, 32'h0);
    chk("rst_busy0", {31'h0, busy0}, 32'h0);
    chk("rst_done0", {31'h0, done0}, 32'h0);
    chk("rst_resp0", {16'h0, resp0}, 32'h0);
    chk("rst_ssn1",  {29'h0, ssn1},  32'h7);

    // Sensor WHO_AM_I read with timing monitor
    s0 = ss_low0; s1 = rises0; s2 = badper0; s3 = mosibad0;
    start0(16'h8F00, 32'h006A);
    chk("busy0_front", {31'h0, busy0}, 32'h1);
    finish0(lat);
    chk("lat0",       lat, 545);
    chk("ssn0_end",   {31'h0, ssn0},  32'h1);
    chk("busy0_end",  {31'h0, busy0}, 32'h0);
    chk("ss_low0",    ss_low0 - s0, 544);
    chk("rises0",     rises0 - s1, 16);
    chk("period0",    badper0 - s2, 0);
    chk("mosi_stab0", mosibad0 - s3, 0);

    // Held burst: SS_n[0] must stay low across both words
    exp_ssn1 = 3'b110;
    s0 = ss_rise1;
    start1(8'hA5, 2'd0, 2'b00, 1'b1, 32'hA5);
    finish1(lat);
    chk("lat1_a",   lat, 37);
    chk("held_busy", {31'h0, busy1}, 32'h0);
    chk("held_ssn",  {29'h0, ssn1},  32'h6);
    chk("held_done", {31'h0, done1}, 32'h1);
    start1(8'h3C, 2'd2, 2'b11, 1'b0, 32'h3C);
    chk("held_clr_done", {31'h0, done1}, 32'h0);
    chk("held_ssn_xfer", {29'h0, ssn1},  32'h6);
    finish1(lat);
    chk("lat1_b",    lat, 35);
    chk("burst_ssn", {29'h0, ssn1}, 32'h7);
    chk("burst_rise", ss_rise1 - s0, 1);

    // Chip select 2, then out-of-range select 3
    exp_ssn1 = 3'b011;
    s0 = nlow1; s1 = bad1; s2 = rises1;
    start1(8'h5A, 2'd2, 2'b00, 1'b0, 32'h5A);
    finish1(lat);
    chk("ss2_low",   nlow1 - s0, 36);
    chk("ss2_bad",   bad1 - s1, 0);
    chk("ss2_rises", rises1 - s2, 8);
    exp_ssn1 = 3'b111;
    s0 = nlow1; s2 = rises1;
    start1(8'hC3, 2'd3, 2'b00, 1'b0, 32'hC3);
    finish1(lat);
    chk("ss3_lat",   lat, 37);
    chk("ss3_low",   nlow1 - s0, 0);
    chk("ss3_rises", rises1 - s2, 8);
    chk("ss3_done",  {31'h0, done1}, 32'h1);

    // 24-bit loopback in modes 3, 1, 2
    chk("sclk2_idle", {31'h0, sclk2}, 32'h0);
    start2(24'hC0FFEE, 2'b11, 32'h00C0FFEE);
    chk("sclk2_front", {31'h0, sclk2}, 32'h1);
    finish2(lat);
    chk("lat2", lat, 201);
    chk("sclk2_after11", {31'h0, sclk2}, 32'h1);
    start2(24'hC0FFEE, 2'b01, 32'h00C0FFEE);
    finish2(lat);
    chk("sclk2_after01", {31'h0, sclk2}, 32'h0);
    start2(24'hC0FFEE, 2'b10, 32'h00C0FFEE);
    finish2(lat);
    chk("sclk2_after10", {31'h0, sclk2}, 32'h1);

    // snd while busy is ignored
    start0(16'h8F00, 32'h006A);
    repeat (100) step();
    snd0 = 1'b1; cmd0 = 16'h0000;
    step();
    snd0 = 1'b0;
    finish0(lat);
    chk("ign_lat", lat, 545);

    // Reset in the middle of XFER
    snd0 = 1'b1; cmd0 = 16'h8F00;
    step();
    snd0 = 1'b0;
    repeat (200) step();
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    chk("mid_rst_ssn",  {31'h0, ssn0},  32'h1);
    chk("mid_rst_sclk", {31'h0, sclk0}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy0}, 32'h0);
    chk("mid_rst_done", {31'h0, done0}, 32'h0);
    chk("mid_rst_resp", {16'h0, resp0}, 32'h0);

    // rls and snd together in HELD: release wins
    start1(8'h96, 2'd1, 2'b00, 1'b1, 32'h96);
    finish1(lat);
    chk("rls_held_ssn", {29'h0, ssn1}, 32'h5);
    s0 = rises1;
    rls1 = 1'b1; snd1 = 1'b1; cmd1 = 8'hFF;
    step();
    rls1 = 1'b0; snd1 = 1'b0;
    chk("rls_ssn",  {29'h0, ssn1},  32'h7);
    chk("rls_busy", {31'h0, busy1}, 32'h0);
    repeat (30) step();
    chk("rls_done",  {31'h0, done1}, 32'h1);
    chk("rls_resp",  {24'h0, resp1}, 32'h96);
    chk("rls_rises", rises1 - s0, 0);
    chk("rls_busy2", {31'h0, busy1}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
